// File: rtl/psmac_div.sv
`default_nettype none
// ============================================================================
// Module      : psmac_div
// Description : Sequential restoring divider for the PSMAC datapath. Each
//               iteration is one shift-and-subtract step. Quotient, remainder
//               and a divide-by-zero flag are returned through a
//               start/busy/done handshake.
//               Optional macro PSMAC_DIV_SIGNED_EN enables two's complement
//               operands (magnitude division followed by a FIX sign stage).
// Revision    : 1.0 - initial release
// ============================================================================
module psmac_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int c_CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
`ifdef PSMAC_DIV_SIGNED_EN
    localparam logic [1:0] c_ST_FIX  = 2'd2;
`endif
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_prem;   // partial remainder
    logic [WIDTH-1:0] r_qsh;    // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvs;    // latched divisor (magnitude in signed build)
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;
`ifdef PSMAC_DIV_SIGNED_EN
    logic             r_qneg;
    logic             r_rneg;
`endif

    logic [WIDTH:0]   w_pr;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_prem_nx;
    logic [WIDTH-1:0] w_qsh_nx;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_last;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // Since the partial remainder is always below the divisor, the shifted
    // value is below twice the divisor, so bit WIDTH of the trial is the borrow.
    always_comb begin
        w_pr      = {r_prem, r_qsh[WIDTH-1]};
        w_trial   = w_pr - {1'b0, r_dvs};
        w_borrow  = w_trial[WIDTH];
        w_prem_nx = w_borrow ? w_pr[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_qsh_nx  = {r_qsh[WIDTH-2:0], ~w_borrow};
        w_last    = (r_cnt == c_CNT_ONE);
    end

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
    // still fits unsigned in WIDTH bits, so MIN / -1 wraps back to MIN.
    always_comb begin
`ifdef PSMAC_DIV_SIGNED_EN
        w_mag_a = dividend[WIDTH-1] ? -dividend : dividend;
        w_mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
        w_mag_a = dividend;
        w_mag_b = divisor;
`endif
    end

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_prem  <= '0;
            r_qsh   <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
`ifdef PSMAC_DIV_SIGNED_EN
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_cnt  <= c_CNT_INIT;
                        r_prem <= '0;
                        r_qsh  <= w_mag_a;
                        r_dvs  <= w_mag_b;
                        r_dbz  <= (divisor == '0);
`ifdef PSMAC_DIV_SIGNED_EN
                        r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_rneg <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            // Divide by zero resolves immediately.
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_RUN;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_prem <= w_prem_nx;
                    r_qsh  <= w_qsh_nx;
                    r_cnt  <= r_cnt - c_CNT_ONE;
                    if (w_last) begin
`ifdef PSMAC_DIV_SIGNED_EN
                        r_state <= c_ST_FIX;
`else
                        r_quot  <= w_qsh_nx;
                        r_rem   <= w_prem_nx;
                        r_state <= c_ST_DONE;
`endif
                    end
                end
`ifdef PSMAC_DIV_SIGNED_EN
                c_ST_FIX: begin
                    // Restore signs: quotient truncates toward zero and the
                    // remainder follows the dividend's sign.
                    r_quot  <= r_qneg ? -r_qsh  : r_qsh;
                    r_rem   <= r_rneg ? -r_prem : r_prem;
                    r_state <= c_ST_DONE;
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
`ifdef PSMAC_DIV_SIGNED_EN
        busy = (r_state == c_ST_RUN) || (r_state == c_ST_FIX);
`else
        busy = (r_state == c_ST_RUN);
`endif
        done = (r_state == c_ST_DONE);
        quot = r_quot;
        rem  = r_rem;
        dbz  = r_dbz;
    end

endmodule
`default_nettype wire

// File: tb/tb_psmac_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_psmac_div
// Description : Self-checking bench for psmac_div (WIDTH=8). Expected results
//               come from a plain-arithmetic reference model. Honours
//               PSMAC_DIV_SIGNED_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psmac_div;

    localparam int W = 8;
`ifdef PSMAC_DIV_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         dbz;

    int n_tests = 0;
    int n_fail  = 0;

    psmac_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic definition of division.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef PSMAC_DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef PSMAC_DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    // Stimulus helper: start must already be driven; returns at the negedge
    // where done is seen (cyc = cycle index after the accepting edge, -1 on
    // timeout), with the busy cycle count and any busy/done overlap.
    task automatic wait_done(output int cyc, output int nbusy, output bit overlap);
        cyc = 0;
        nbusy = 0;
        overlap = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy && done) overlap = 1'b1;
            if (busy) nbusy++;
        end while (!done && cyc < 60);
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (quot !== '0) begin n_fail++; $display("FAIL reset_quot got=%h exp=00", quot); end
        n_tests++; if (rem  !== '0) begin n_fail++; $display("FAIL reset_rem got=%h exp=00", rem); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (dbz  !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] eq, er; logic ez;
        int cyc, nb; bit ov;
        model(8'd100, 8'd7, eq, er, ez);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        wait_done(cyc, nb, ov);
        n_tests++; if (cyc !== LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, LAT); end
        n_tests++; if (nb !== LAT - 1) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", nb, LAT - 1); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done_overlap got=%b exp=0", ov); end
        n_tests++; if (quot !== eq) begin n_fail++; $display("FAIL basic_quot got=%h exp=%h", quot, eq); end
        n_tests++; if (rem !== er) begin n_fail++; $display("FAIL basic_rem got=%h exp=%h", rem, er); end
        n_tests++; if (dbz !== ez) begin n_fail++; $display("FAIL basic_dbz got=%b exp=%b", dbz, ez); end
        // done must last exactly one cycle and results must hold in IDLE
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        n_tests++; if (quot !== eq) begin n_fail++; $display("FAIL basic_quot_hold got=%h exp=%h", quot, eq); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eq1, er1, eq2, er2; logic ez1, ez2;
        int cyc, nb; bit ov;
        model(8'd255, 8'd1, eq1, er1, ez1);
        model(8'd3, 8'd200, eq2, er2, ez2);
        start = 1'b1; dividend = 8'd255; divisor = 8'd1;
        wait_done(cyc, nb, ov);
        n_tests++; if (quot !== eq1 || rem !== er1) begin n_fail++; $display("FAIL b2b_first got=%h r%h exp=%h r%h", quot, rem, eq1, er1); end
        // second start coincident with the first done
        start = 1'b1; dividend = 8'd3; divisor = 8'd200;
        wait_done(cyc, nb, ov);
        n_tests++; if (cyc !== LAT) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc, LAT); end
        n_tests++; if (quot !== eq2 || rem !== er2) begin n_fail++; $display("FAIL b2b_second got=%h r%h exp=%h r%h", quot, rem, eq2, er2); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap got=%b exp=0", ov); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        logic [W-1:0] eq, er; logic ez;
        int cyc, nb; bit ov;
        start = 1'b1; dividend = 8'd5; divisor = 8'd0;
        wait_done(cyc, nb, ov);
        n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
        n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL dbz_busy got=%0d exp=0", nb); end
        n_tests++; if (quot !== 8'hFF) begin n_fail++; $display("FAIL dbz_quot got=%h exp=ff", quot); end
        n_tests++; if (rem !== 8'd5) begin n_fail++; $display("FAIL dbz_rem got=%h exp=05", rem); end
        n_tests++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
        repeat (3) @(negedge clk);
        n_tests++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_hold got=%b exp=1", dbz); end
        model(8'd20, 8'd4, eq, er, ez);
        start = 1'b1; dividend = 8'd20; divisor = 8'd4;
        wait_done(cyc, nb, ov);
        n_tests++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL dbz_clear got=%b exp=0", dbz); end
        n_tests++; if (quot !== eq || rem !== er) begin n_fail++; $display("FAIL dbz_next got=%h r%h exp=%h r%h", quot, rem, eq, er); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] eq, er, gq, gr; logic ez;
        int ndone, first;
        model(8'd200, 8'd9, eq, er, ez);
        ndone = 0; first = -1; gq = '0; gr = '0;
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; gq = quot; gr = rem; end
            end
            start = (c == 4);
            if (c == 4) begin dividend = 8'd9; divisor = 8'd3; end
        end
        n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        n_tests++; if (first !== LAT) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", first, LAT); end
        n_tests++; if (gq !== eq || gr !== er) begin n_fail++; $display("FAIL ignore_result got=%h r%h exp=%h r%h", gq, gr, eq, er); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] eq, er; logic ez;
        int ndone, cyc, nb; bit ov;
        start = 1'b1; dividend = 8'd77; divisor = 8'd3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if (quot !== '0 || rem !== '0) begin n_fail++; $display("FAIL arst_results got=%h r%h exp=00 r00", quot, rem); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_handshake got busy=%b done=%b exp 0 0", busy, done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL arst_no_done got=%0d exp=0", ndone); end
        model(8'd50, 8'd5, eq, er, ez);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        wait_done(cyc, nb, ov);
        n_tests++; if (quot !== eq || rem !== er || cyc !== LAT) begin n_fail++; $display("FAIL arst_fresh got=%h r%h lat=%0d exp=%h r%h lat=%0d", quot, rem, cyc, eq, er, LAT); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er; logic ez;
        int cyc, nb; bit ov, b2b;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            b2b = $urandom_range(0, 1);
            model(a, b, eq, er, ez);
            start = 1'b1; dividend = a; divisor = b;
            wait_done(cyc, nb, ov);
            n_tests++;
            if (quot !== eq || rem !== er || dbz !== ez || ov !== 1'b0 ||
                cyc !== ((b == '0) ? 1 : LAT)) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h got=%h r%h z%b lat=%0d exp=%h r%h z%b",
                         i, a, b, quot, rem, dbz, cyc, eq, er, ez);
            end
            if (!b2b) @(negedge clk);
        end
        @(negedge clk);
    endtask

`ifdef PSMAC_DIV_SIGNED_EN
    task automatic test_signed();
        int cyc, nb; bit ov;
        start = 1'b1; dividend = 8'hF9; divisor = 8'd2;
        wait_done(cyc, nb, ov);
        n_tests++; if (quot !== 8'hFD || rem !== 8'hFF || cyc !== 10) begin n_fail++; $display("FAIL signed_m7_2 got=%h r%h lat=%0d exp=fd rff lat=10", quot, rem, cyc); end
        start = 1'b1; dividend = 8'h80; divisor = 8'hFF;
        wait_done(cyc, nb, ov);
        n_tests++; if (quot !== 8'h80 || rem !== 8'h00 || dbz !== 1'b0) begin n_fail++; $display("FAIL signed_min_m1 got=%h r%h z%b exp=80 r00 z0", quot, rem, dbz); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_async_reset();
`ifdef PSMAC_DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
